a2d_arbiter: RTL and testbench

Shares the single external A2D converter between up to NREQ independent requesters: motion sensing, battery monitor, diagnostics. Each requester asks for a conversion on a 3-bit channel. The block grants requesters round-robin, drives strt_cnv/chnnl, waits for cnv_cmplt, and returns the 12-bit result with a one-cycle done pulse. It sits between the requesting controllers and the A2D interface block.

---
 rtl/a2d_arb_pkg.sv | 16 +
 rtl/a2d_arbiter_rr.sv | 35 +++
 rtl/a2d_arbiter.sv | 124 ++++++++++++
 tb/tb_a2d_arbiter.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/a2d_arb_pkg.sv
// a2d_arbiter shared types and constants.
// Pulled in by every a2d_arbiter source file.
package a2d_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int A2D_W       = 12;
    localparam int CHNL_W      = 3;
    localparam int TIMEOUT_DEF = 4095;

endpackage

// File: rtl/a2d_arbiter_rr.sv
// Combinational round-robin pick: search starts one past ptr.
// Returns a one-hot winner, its index and an any-request flag.
module rr_arbiter
    import a2d_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] win,
    output logic [IW-1:0]   win_idx,
    output logic            any
);

    logic [IW-1:0] idx;

    always_comb begin
        win     = '0;
        win_idx = '0;
        any     = 1'b0;
        idx     = '0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = IW'((int'(ptr) + k) % NREQ);
            if (!any && req[idx]) begin
                any     = 1'b1;
                win_idx = idx;
            end
        end
        if (any) begin
            win = NREQ'(1) << win_idx;
        end
    end

endmodule

// File: rtl/a2d_arbiter.sv
// Round-robin sharing of one A2D converter among NREQ requesters.
// Define A2D_ARB_TIMEOUT_EN to abort a stuck conversion after TIMEOUT cycles.
module a2d_arbiter
    import a2d_arb_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NREQ-1:0]          req,
    input  logic [CHNL_W*NREQ-1:0]   req_chnnl,
    output logic [NREQ-1:0]          gnt,
    output logic [NREQ-1:0]          done,
    output logic [A2D_W-1:0]         res,
    output logic                     err,
    output logic                     strt_cnv,
    output logic [CHNL_W-1:0]        chnnl,
    input  logic                     cnv_cmplt,
    input  logic [A2D_W-1:0]         A2D_res
);

    localparam int IW = $clog2(NREQ);

    // Out-of-range configurations elaborate this marker block.
    if (NREQ < 2 || NREQ > 8 || TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_cfg
    end

    state_t             state;
    logic [IW-1:0]      ptr;
    logic [NREQ-1:0]    win;
    logic [IW-1:0]      win_idx;
    logic               any;
    logic [CHNL_W-1:0]  sel_ch;

    rr_arbiter #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_rr (
        .req     (req),
        .ptr     (ptr),
        .win     (win),
        .win_idx (win_idx),
        .any     (any)
    );

    always_comb begin
        sel_ch = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win_idx == IW'(i)) begin
                sel_ch = req_chnnl[i*CHNL_W +: CHNL_W];
            end
        end
    end

`ifdef A2D_ARB_TIMEOUT_EN
    logic [15:0] cnt;
`else
    assign err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            ptr      <= IW'(NREQ - 1);
            gnt      <= '0;
            done     <= '0;
            res      <= '0;
            strt_cnv <= 1'b0;
            chnnl    <= '0;
`ifdef A2D_ARB_TIMEOUT_EN
            err      <= 1'b0;
            cnt      <= '0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    gnt <= '0;
                    if (any) begin
                        gnt      <= win;
                        chnnl    <= sel_ch;
                        ptr      <= win_idx;
                        strt_cnv <= 1'b1;
                        state    <= START;
                    end
                end
                START: begin
                    strt_cnv <= 1'b0;
                    state    <= WAIT;
`ifdef A2D_ARB_TIMEOUT_EN
                    cnt      <= '0;
`endif
                end
                WAIT: begin
                    if (cnv_cmplt) begin
                        res   <= A2D_res;
                        done  <= gnt;
                        state <= DONE;
                    end
`ifdef A2D_ARB_TIMEOUT_EN
                    // Abort leaves res untouched; only err flags it.
                    else if (cnt == 16'(TIMEOUT - 1)) begin
                        done  <= gnt;
                        err   <= 1'b1;
                        state <= DONE;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
`endif
                end
                DONE: begin
                    done  <= '0;
                    gnt   <= '0;
                    state <= IDLE;
`ifdef A2D_ARB_TIMEOUT_EN
                    err   <= 1'b0;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_a2d_arbiter.sv
// Self-checking bench for a2d_arbiter: directed scenarios plus random
// traffic against a queue-free round-robin reference model.
module tb_a2d_arbiter;
    import a2d_arb_pkg::*;

    localparam int NREQ = 4;
    localparam int TMO  = 100;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic [NREQ-1:0]        req;
    logic [CHNL_W*NREQ-1:0] req_chnnl;
    logic [NREQ-1:0]        gnt;
    logic [NREQ-1:0]        done;
    logic [A2D_W-1:0]       res;
    logic                   err;
    logic                   strt_cnv;
    logic [CHNL_W-1:0]      chnnl;
    logic                   cnv_cmplt;
    logic [A2D_W-1:0]       A2D_res;

    int          n_chk  = 0;
    int          n_fail = 0;
    int          m_ptr;
    logic [11:0] m_res;
    int          w;

    always #5 clk = ~clk;

    a2d_arbiter #(
        .NREQ    (NREQ),
        .TIMEOUT (TMO)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .req_chnnl (req_chnnl),
        .gnt       (gnt),
        .done      (done),
        .res       (res),
        .err       (err),
        .strt_cnv  (strt_cnv),
        .chnnl     (chnnl),
        .cnv_cmplt (cnv_cmplt),
        .A2D_res   (A2D_res)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: first requester after the last winner, wrapping.
    function automatic int pick(input logic [NREQ-1:0] r);
        for (int k = 1; k <= NREQ; k++) begin
            int i;
            i = (m_ptr + k) % NREQ;
            if (r[i]) return i;
        end
        return -1;
    endfunction

    task automatic chk_zero(input string tag);
        chk({tag, "_gnt"},  gnt,      0);
        chk({tag, "_done"}, done,     0);
        chk({tag, "_res"},  res,      0);
        chk({tag, "_err"},  err,      0);
        chk({tag, "_strt"}, strt_cnv, 0);
        chk({tag, "_ch"},   chnnl,    0);
    endtask

    // Enter from an IDLE cycle with req already driven; lat<0 means the
    // A2D never completes. Leaves the DUT in the following IDLE cycle.
    task automatic txn(input int lat, input bit spur, input bit drop,
                       input logic [11:0] val, output int wo);
        logic [2:0] ec;
        int         wi;
        wi = pick(req);
        wo = wi;
        if (wi < 0) begin
            chk("txn_no_req", 0, 1);
            return;
        end
        ec = req_chnnl[wi*3 +: 3];
        tick();
        m_ptr = wi;
        chk("start_gnt",   gnt,      32'(1) << wi);
        chk("start_strt",  strt_cnv, 1);
        chk("start_chnnl", chnnl,    ec);
        chk("start_done",  done,     0);
        if (drop) req[wi] = 1'b0;
        if (spur) cnv_cmplt = 1'b1;
        repeat ((lat < 0) ? TMO : lat) begin
            tick();
            cnv_cmplt = 1'b0;
            chk("wait_strt",   strt_cnv,      0);
            chk("wait_done",   done,          0);
            chk("wait_gnt",    gnt,           32'(1) << wi);
            chk("wait_onehot", $onehot0(gnt), 1);
            chk("wait_res",    res,           m_res);
        end
        if (lat >= 0) begin
            A2D_res   = val;
            cnv_cmplt = 1'b1;
            tick();
            cnv_cmplt = 1'b0;
            A2D_res   = 12'($urandom);
            m_res     = val;
            chk("done_err", err, 0);
        end else begin
            tick();
            chk("done_err", err, 1);
        end
        chk("done_pulse", done, 32'(1) << wi);
        chk("done_res",   res,  m_res);
        chk("done_gnt",   gnt,  32'(1) << wi);
        tick();
        chk("idle_gnt",   gnt,   0);
        chk("idle_done",  done,  0);
        chk("idle_err",   err,   0);
        chk("idle_res",   res,   m_res);
        chk("idle_chnnl", chnnl, ec);
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req       = '0;
        cnv_cmplt = 1'b0;
        #1;
        chk_zero("rst");
        m_ptr = NREQ - 1;
        m_res = '0;
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n     = 1'b0;
        req       = '0;
        req_chnnl = '0;
        cnv_cmplt = 1'b0;
        A2D_res   = '0;
        m_ptr     = NREQ - 1;
        m_res     = '0;
        tick();
        tick();
        chk_zero("por");
        rst_n = 1'b1;
        tick();
        chk("idle0_gnt", gnt, 0);

        // single request
        req_chnnl = 12'h001;
        req       = 4'b0001;
        txn(10, 1'b0, 1'b1, 12'h5A3, w);
        chk("single_w",   w,     0);
        chk("single_res", res,   12'h5A3);
        chk("single_ch",  chnnl, 1);

        // contention: all four held, channels 0,4,2,3
        do_reset();
        req_chnnl = {3'd3, 3'd2, 3'd4, 3'd0};
        req       = 4'b1111;
        for (int i = 0; i < 6; i++) begin
            txn(1 + i, 1'b0, 1'b0, 12'($urandom), w);
            chk("cont_order", w, i % 4);
        end
        req = '0;
        tick();

        // fairness: 0 re-requests while 2 waits
        do_reset();
        req_chnnl = {3'd7, 3'd5, 3'd6, 3'd2};
        req       = 4'b0101;
        txn(3, 1'b0, 1'b0, 12'h111, w);
        chk("fair_first", w, 0);
        txn(2, 1'b0, 1'b1, 12'h222, w);
        chk("fair_next", w, 2);
        txn(2, 1'b0, 1'b1, 12'h333, w);
        chk("fair_last", w, 0);

        // spurious completes in IDLE and START
        A2D_res   = 12'hFFF;
        cnv_cmplt = 1'b1;
        tick();
        cnv_cmplt = 1'b0;
        chk("spur_done", done, 0);
        chk("spur_res",  res,  m_res);
        chk("spur_gnt",  gnt,  0);
        req = 4'b1000;
        txn(4, 1'b1, 1'b1, 12'h0C3, w);
        chk("spur_w", w, 3);

        // reset during WAIT
        req = 4'b1111;
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        chk_zero("midrst");
        m_ptr = NREQ - 1;
        m_res = '0;
        req   = 4'b1010;
        #2;
        rst_n = 1'b1;
        txn(2, 1'b0, 1'b1, 12'h7E1, w);
        chk("rst_w", w, 1);

`ifdef A2D_ARB_TIMEOUT_EN
        req = 4'b0101;
        txn(-1, 1'b0, 1'b1, 12'h000, w);
        chk("tmo_w", w, 2);
        txn(5, 1'b0, 1'b1, 12'hABC, w);
        chk("tmo_next", w, 0);
`endif

        // random traffic
        req = '0;
        for (int n = 0; n < 40; n++) begin
            if (req == '0) begin
                logic [NREQ-1:0] r;
                r = NREQ'($urandom_range(1, 15));
                for (int i = 0; i < NREQ; i++) begin
                    if (r[i]) req_chnnl[i*3 +: 3] = 3'($urandom);
                end
                req = r;
            end
            txn($urandom_range(1, 8), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), 12'($urandom), w);
            for (int i = 0; i < NREQ; i++) begin
                if (!req[i] && $urandom_range(0, 2) == 0) begin
                    req_chnnl[i*3 +: 3] = 3'($urandom);
                    req[i] = 1'b1;
                end
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
